// File: rtl/stream_mux_pkg.sv
// Shared constants for the N-to-1 stream multiplexer: mode encodings,
// default sizing and the channel-index width helper.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N     = 4;

    // A channel index needs at least one bit even for degenerate N.
    function automatic int selw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel
// at or after ptr, wrapping modulo N.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int SELW = selw_f(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            grant_valid,
    output logic [SELW-1:0] grant
);

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant       = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream mux with explicit-select and round-robin modes
// and a single registered output stage. Optional packet lock: STREAM_MUX_PKT_LOCK_EN.
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = selw_f(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             lock_q, lock_d;
    logic [SELW-1:0]  lock_chan_q, lock_chan_d;
`endif

    logic             load_ok;
    logic             gv;
    logic [SELW-1:0]  g;
    logic [WIDTH-1:0] g_data;
    logic             g_last;
    logic             xfer;
    logic             rr_gv;
    logic [SELW-1:0]  rr_g;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr_q),
        .grant_valid (rr_gv),
        .grant       (rr_g)
    );

    // Grant selection; sel values outside 0..N-1 never match a channel.
    always_comb begin
        load_ok = !out_valid_q || out_ready;
        gv      = 1'b0;
        g       = '0;
        if (mode == MODE_RR) begin
            gv = rr_gv;
            g  = rr_g;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (SELW'(i) == sel && in_valid[i]) begin
                    gv = 1'b1;
                    g  = sel;
                end
            end
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock_q) begin
            gv = 1'b0;
            g  = lock_chan_q;
            for (int i = 0; i < N; i++) begin
                if (SELW'(i) == lock_chan_q && in_valid[i]) gv = 1'b1;
            end
        end
`endif
        g_data   = '0;
        g_last   = 1'b0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (SELW'(i) == g) begin
                g_data      = in_data[i*WIDTH +: WIDTH];
                g_last      = in_last[i];
                in_ready[i] = gv && load_ok && !rst;
            end
        end
        xfer = gv && load_ok && !rst;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = g_data;
            out_chan_d  = g;
            out_last_d  = g_last;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        lock_d      = lock_q;
        lock_chan_d = lock_chan_q;
        if (xfer) begin
            lock_d      = !g_last;
            lock_chan_d = g;
        end
        // Arbitration advances only once the whole packet has gone through.
        if (xfer && mode == MODE_RR && g_last)
            rr_ptr_d = (g == SELW'(N-1)) ? '0 : g + 1'b1;
`else
        if (xfer && mode == MODE_RR)
            rr_ptr_d = (g == SELW'(N-1)) ? '0 : g + 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_chan_q <= lock_chan_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench for stream_mux_nto1 (N=4, WIDTH=32): a vector table plus
// hand-written reset, backpressure and packet sequences.
module tb_stream_mux_nto1;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [1:0]     sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_chan;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;

    int total = 0;
    int bad   = 0;

    stream_mux_nto1 #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_ch;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {28'd0, out_valid, out_chan, out_last, out_data};
    endfunction

    function automatic logic [63:0] mk(input logic v, input logic [1:0] c, input logic l, input logic [31:0] d);
        return {28'd0, v, c, l, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_seq[4];
        int beat;
        logic r1;

        // ch0..3 = 0x15, 0x9, 0xA, 0xF
        tbl[0]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h15};
        tbl[1]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hF};
        tbl[2]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hF};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h15};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h9};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hF};
        tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h15};
        tbl[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h9};
        tbl[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hF};
        tbl[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h9};
        tbl[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hF};
        tbl[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hF};
        tbl[13] = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hF};
        tbl[14] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hF};
        tbl[15] = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 32'h9};

        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = {32'hF, 32'hA, 32'h9, 32'h15};
        in_valid  = 4'b1111;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        #1;
        chk("rdy_in_rst", 64'(in_ready), 64'h0);
        tick();
        tick();
        chk("reset_outs", outs(), mk(1'b0, 2'd0, 1'b0, 32'h0));
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            mode      = tbl[k].mode;
            sel       = tbl[k].sel;
            in_valid  = tbl[k].vld;
            out_ready = tbl[k].ordy;
            #1;
            chk($sformatf("vec%0d_rdy", k), 64'(in_ready), 64'(tbl[k].exp_rdy));
            tick();
            chk($sformatf("vec%0d_out", k), outs(),
                mk(tbl[k].exp_ov, tbl[k].exp_ch, 1'b0, tbl[k].exp_d));
        end

        // Backpressure: 0x1A held for three stalled cycles, then replaced.
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        in_data[2*W +: W] = 32'h1A;
        in_valid = 4'b0100;
        tick();
        chk("bp_load", outs(), mk(1'b1, 2'd2, 1'b0, 32'h1A));
        in_data[2*W +: W] = 32'h55;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_rdy%0d", k), 64'(in_ready), 64'h0);
            tick();
            chk($sformatf("bp_hold%0d", k), outs(), mk(1'b1, 2'd2, 1'b0, 32'h1A));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(in_ready), 64'b0100);
        tick();
        chk("bp_release_out", outs(), mk(1'b1, 2'd2, 1'b0, 32'h55));

        // Reset mid-stream with rr_ptr at 2.
        mode = 1'b1; in_valid = 4'b0010;
        tick();
        chk("pre_rst", outs(), mk(1'b1, 2'd1, 1'b0, 32'h9));
        rst = 1'b1; in_valid = 4'b1111;
        #1;
        chk("mid_rst_rdy", 64'(in_ready), 64'h0);
        tick();
        chk("mid_rst_outs", outs(), mk(1'b0, 2'd0, 1'b0, 32'h0));
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 64'(in_ready), 64'b0001);
        tick();
        chk("post_rst_out", outs(), mk(1'b1, 2'd0, 1'b0, 32'h15));

        // Packet of 3 beats on ch1 while ch2 keeps requesting single-beat packets.
`ifdef STREAM_MUX_PKT_LOCK_EN
        exp_seq = '{2'd1, 2'd1, 2'd1, 2'd2};
`else
        exp_seq = '{2'd1, 2'd2, 2'd1, 2'd2};
`endif
        beat     = 0;
        in_valid = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            in_last = {1'b0, 1'b1, (beat == 2), 1'b0};
            #1;
            r1 = in_ready[1];
            tick();
            if (r1) beat++;
            chk($sformatf("pkt_chan%0d", k), 64'(out_chan), 64'(exp_seq[k]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
